// File: rtl/psram_access_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// psram_access_arbiter_pkg
//   Shared definitions for the PSRAM access arbiter: FSM state encoding,
//   burst-owner codes and the burst size shared with the burst engine.
//   No ports (package).
// -----------------------------------------------------------------------------
package psram_access_arbiter_pkg;

  // 16 halfwords = 32 bytes per burst; the engine uses the same value.
  localparam int unsigned PSRAM_BURST_LOG2 = 5;

  typedef enum logic [1:0] {
    ST_INIT_WAIT = 2'd0,
    ST_IDLE      = 2'd1,
    ST_ISSUE     = 2'd2,
    ST_BUSY      = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_HOST = 2'd2
  } arb_owner_e;

endpackage

// File: rtl/psram_access_arbiter_watchdog.sv
// -----------------------------------------------------------------------------
// psram_access_arbiter_watchdog
//   Engine watchdog: counts cycles while a burst is outstanding and flags a
//   sticky error when the engine fails to finish within TIMEOUT_CYCLES.
//   Only compiled when PSRAM_ARB_TIMEOUT_EN is defined; the default build
//   leaves this file empty.
// Ports:
//   clock       in  system clock
//   reset       in  synchronous, active-high
//   active      in  a burst is outstanding (arbiter in ISSUE or BUSY)
//   clear       in  the burst is finishing normally this cycle
//   expire      out combinational: limit reached this cycle
//   timeout_err out sticky error flag, cleared only by reset
// -----------------------------------------------------------------------------
`ifdef PSRAM_ARB_TIMEOUT_EN
module psram_access_arbiter_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic clock,
  input  logic reset,
  input  logic active,
  input  logic clear,
  output logic expire,
  output logic timeout_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // The count covers the first outstanding cycle as cycle 0, so the flag
  // becomes visible exactly TIMEOUT_CYCLES cycles after the grant.
  assign expire = active && !clear && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | expire;
    if (!active || clear || expire) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;

endmodule
`endif

// File: rtl/psram_access_arbiter.sv
// -----------------------------------------------------------------------------
// psram_access_arbiter
//   Shares the single PSRAM burst engine between the display refresh reader
//   (priority) and the host write port. A streak limit on consecutive display
//   grants keeps the host making progress. All traffic is held off until the
//   engine reports init_done.
//   Optional feature macro: PSRAM_ARB_TIMEOUT_EN (engine watchdog, adds the
//   TIMEOUT_CYCLES parameter).
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   init_done             engine finished PSRAM reset/EID sequence
//   disp_req/disp_addr    display burst-read request and address
//   disp_grant/disp_done  1-cycle pulses: accepted / finished
//   host_req/host_addr    host burst-write request and address
//   host_grant/host_done  1-cycle pulses: accepted / finished
//   eng_start             command valid to engine, held until eng_busy
//   eng_write             1 = write burst (host), 0 = read burst (display)
//   eng_addr              burst-aligned address
//   eng_busy, eng_done    engine status: executing / end-of-burst pulse
//   timeout_err           sticky watchdog error (0 without the macro)
// -----------------------------------------------------------------------------
module psram_access_arbiter
  import psram_access_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W          = 24,
  parameter int unsigned BURST_LOG2      = PSRAM_BURST_LOG2,
`ifdef PSRAM_ARB_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES  = 4096,
`endif
  parameter int unsigned MAX_DISP_STREAK = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              init_done,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_grant,
  output logic              disp_done,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  output logic              host_grant,
  output logic              host_done,
  output logic              eng_start,
  output logic              eng_write,
  output logic [ADDR_W-1:0] eng_addr,
  input  logic              eng_busy,
  input  logic              eng_done,
  output logic              timeout_err
);

  localparam int unsigned STREAK_W = $clog2(MAX_DISP_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DISP_STREAK);
  localparam logic [ADDR_W-1:0] ALIGN_MASK =
    {{(ADDR_W - BURST_LOG2){1'b1}}, {BURST_LOG2{1'b0}}};

  arb_state_e          state_q, state_d;
  arb_owner_e          owner_q, owner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [ADDR_W-1:0]   eng_addr_q, eng_addr_d;
  logic                eng_write_q, eng_write_d;
  logic                eng_start_q, eng_start_d;
  logic                disp_grant_q, disp_grant_d;
  logic                host_grant_q, host_grant_d;
  logic                disp_done_q, disp_done_d;
  logic                host_done_q, host_done_d;

  logic disp_win, host_win, burst_end, wd_expire;

  // Display wins unless the host is waiting and display already used up
  // its streak allowance.
  assign disp_win = disp_req && !(host_req && (streak_q == STREAK_MAX));
  assign host_win = host_req && !disp_win;

`ifdef PSRAM_ARB_TIMEOUT_EN
  logic wd_active, wd_clear;
  assign wd_active = (state_q == ST_ISSUE) || (state_q == ST_BUSY);
  assign wd_clear  = (state_q == ST_BUSY) && eng_done;

  psram_access_arbiter_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock      (clock),
    .reset      (reset),
    .active     (wd_active),
    .clear      (wd_clear),
    .expire     (wd_expire),
    .timeout_err(timeout_err)
  );
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    eng_addr_d   = eng_addr_q;
    eng_write_d  = eng_write_q;
    eng_start_d  = 1'b0;
    disp_grant_d = 1'b0;
    host_grant_d = 1'b0;
    disp_done_d  = 1'b0;
    host_done_d  = 1'b0;
    burst_end    = 1'b0;

    case (state_q)
      ST_INIT_WAIT: begin
        if (init_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (!init_done) begin
          state_d = ST_INIT_WAIT;
        end else if (disp_win) begin
          disp_grant_d = 1'b1;
          owner_d      = OWN_DISP;
          eng_addr_d   = disp_addr & ALIGN_MASK;
          eng_write_d  = 1'b0;
          state_d      = ST_ISSUE;
        end else if (host_win) begin
          host_grant_d = 1'b1;
          owner_d      = OWN_HOST;
          eng_addr_d   = host_addr & ALIGN_MASK;
          eng_write_d  = 1'b1;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // eng_start rises the cycle after the grant; only a busy seen while
        // the command is on the bus counts as acceptance.
        if (eng_start_q && eng_busy) begin
          state_d = ST_BUSY;
        end else begin
          eng_start_d = 1'b1;
        end
      end
      ST_BUSY: begin
        burst_end = eng_done;
      end
      default: begin
        state_d = ST_INIT_WAIT;
      end
    endcase

    // Normal completion and watchdog expiry both release the owner with a
    // done pulse; expiry additionally forces re-initialisation.
    if (burst_end || wd_expire) begin
      disp_done_d = (owner_q == OWN_DISP);
      host_done_d = (owner_q == OWN_HOST);
      owner_d     = OWN_NONE;
      eng_start_d = 1'b0;
      state_d     = (burst_end && init_done) ? ST_IDLE : ST_INIT_WAIT;
    end

    // The streak only matters while the host is actually waiting.
    if (!host_req || host_grant_d) begin
      streak_d = '0;
    end else if (disp_grant_d && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + 1'b1;
    end else begin
      streak_d = streak_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_INIT_WAIT;
      owner_q      <= OWN_NONE;
      streak_q     <= '0;
      eng_addr_q   <= '0;
      eng_write_q  <= 1'b0;
      eng_start_q  <= 1'b0;
      disp_grant_q <= 1'b0;
      host_grant_q <= 1'b0;
      disp_done_q  <= 1'b0;
      host_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      streak_q     <= streak_d;
      eng_addr_q   <= eng_addr_d;
      eng_write_q  <= eng_write_d;
      eng_start_q  <= eng_start_d;
      disp_grant_q <= disp_grant_d;
      host_grant_q <= host_grant_d;
      disp_done_q  <= disp_done_d;
      host_done_q  <= host_done_d;
    end
  end

  assign disp_grant = disp_grant_q;
  assign host_grant = host_grant_q;
  assign disp_done  = disp_done_q;
  assign host_done  = host_done_q;
  assign eng_start  = eng_start_q;
  assign eng_write  = eng_write_q;
  assign eng_addr   = eng_addr_q;

endmodule

// File: tb/tb_psram_access_arbiter.sv
module tb_psram_access_arbiter;

  localparam int MAXS = 4;

  logic        clock = 1'b0;
  logic        reset, init_done;
  logic        disp_req, host_req;
  logic [23:0] disp_addr, host_addr, eng_addr;
  logic        disp_grant, disp_done, host_grant, host_done;
  logic        eng_start, eng_write, eng_busy, eng_done, timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cyc = -10;
  int eng_lat = 0;
  int eng_len = 2;
  bit eng_hang = 1'b0;

  psram_access_arbiter #(
    .ADDR_W(24),
    .BURST_LOG2(5),
`ifdef PSRAM_ARB_TIMEOUT_EN
    .TIMEOUT_CYCLES(16),
`endif
    .MAX_DISP_STREAK(MAXS)
  ) dut (
    .clock(clock), .reset(reset), .init_done(init_done),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_grant(disp_grant), .disp_done(disp_done),
    .host_req(host_req), .host_addr(host_addr),
    .host_grant(host_grant), .host_done(host_done),
    .eng_start(eng_start), .eng_write(eng_write), .eng_addr(eng_addr),
    .eng_busy(eng_busy), .eng_done(eng_done), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [23:0] align(input logic [23:0] a);
    return {a[23:5], 5'b0};
  endfunction

  // Behavioural burst engine: accepts eng_start, goes busy after eng_lat
  // cycles, stays busy eng_len cycles, then pulses eng_done.
  initial begin : engine
    int phase;
    int cnt;
    phase = 0;
    cnt = 0;
    eng_busy = 1'b0;
    eng_done = 1'b0;
    forever begin
      @(negedge clock);
      eng_done = 1'b0;
      if (reset) begin
        eng_busy = 1'b0;
        phase = 0;
      end else begin
        case (phase)
          0: if (eng_start) begin cnt = eng_lat; phase = 1; end
          1: if (cnt == 0) begin eng_busy = 1'b1; cnt = eng_len; phase = 2; end
             else cnt--;
          2: if (cnt == 0) begin
               if (!eng_hang) begin
                 eng_busy = 1'b0; eng_done = 1'b1; done_cyc = cyc; phase = 0;
               end
             end else cnt--;
          default: phase = 0;
        endcase
      end
    end
  end

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b1; init_done = 1'b0;
    disp_req = 1'b0; host_req = 1'b0;
    disp_addr = '0; host_addr = '0;
    repeat (3) tick();
    checks++;
    if ({disp_grant, disp_done, host_grant, host_done, eng_start, eng_write, timeout_err} !== 7'b0)
      $display("FAIL reset_flags got %b required 0000000",
               {disp_grant, disp_done, host_grant, host_done, eng_start, eng_write, timeout_err});
    else checks += 0;
    if ({disp_grant, disp_done, host_grant, host_done, eng_start, eng_write, timeout_err} !== 7'b0) errors++;
    checks++;
    if (eng_addr !== 24'h0) begin
      errors++; $display("FAIL reset_addr got %h required 000000", eng_addr);
    end
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if ({disp_grant, host_grant, eng_start} !== 3'b0) begin
      errors++; $display("FAIL idle_after_reset got %b required 000", {disp_grant, host_grant, eng_start});
    end
    $display("reset: outputs checked");
  endtask

  task automatic test_init_hold;
    int g, t, hp;
    eng_lat = 1; eng_len = 3;
    disp_addr = 24'h00012F; disp_req = 1'b1; init_done = 1'b0;
    g = 0;
    repeat (100) begin
      tick();
      if (disp_grant || host_grant || eng_start) g++;
    end
    checks++;
    if (g != 0) begin errors++; $display("FAIL init_hold got %0d grant cycles required 0", g); end
    init_done = 1'b1;
    t = 0;
    while (!disp_grant && t < 5) begin tick(); t++; end
    checks++;
    if (!disp_grant || t > 2) begin
      errors++; $display("FAIL init_grant_latency got %0d cycles (grant=%b) required <=2", t, disp_grant);
    end
    checks++;
    if (eng_addr !== 24'h000120 || eng_write !== 1'b0 || host_grant !== 1'b0) begin
      errors++; $display("FAIL disp_cmd got addr %h write %b required addr 000120 write 0", eng_addr, eng_write);
    end
    $display("grant D addr %h write %b", eng_addr, eng_write);
    disp_req = 1'b0;
    tick();
    checks++;
    if (eng_start !== 1'b1) begin errors++; $display("FAIL eng_start_after_grant got %b required 1", eng_start); end
    t = 0; hp = 0;
    while (!disp_done && t < 50) begin
      tick(); t++;
      if (host_done || host_grant) hp++;
    end
    checks++;
    if (!disp_done || cyc != done_cyc + 1) begin
      errors++; $display("FAIL disp_done_timing got done=%b at cycle %0d required 1 at cycle %0d", disp_done, cyc, done_cyc + 1);
    end
    checks++;
    if (hp != 0) begin errors++; $display("FAIL no_host_pulses got %0d required 0", hp); end
  endtask

  task automatic test_order;
    int cnt, ng, nd, t, exp_h;
    disp_addr = $urandom; host_addr = $urandom;
    disp_req = 1'b1; host_req = 1'b1;
    ng = 0; nd = 0; cnt = 0; t = 0;
    while (ng < 10 && t < 600) begin
      tick(); t++;
      checks++;
      if (disp_grant && host_grant) begin errors++; $display("FAIL order_double_grant at cycle %0d got 2 grants required 1", cyc); end
      if (disp_done || host_done) nd++;
      if (disp_grant || host_grant) begin
        exp_h = (cnt == MAXS) ? 1 : 0;
        cnt = (exp_h == 1) ? 0 : cnt + 1;
        checks++;
        if (host_grant !== exp_h[0]) begin
          errors++; $display("FAIL order grant %0d got %s required %s", ng, host_grant ? "H" : "D", exp_h == 1 ? "H" : "D");
        end
        checks++;
        if (eng_addr !== align(host_grant ? host_addr : disp_addr) || eng_write !== host_grant) begin
          errors++; $display("FAIL order_cmd grant %0d got addr %h write %b required addr %h write %b",
                             ng, eng_addr, eng_write, align(host_grant ? host_addr : disp_addr), host_grant);
        end
        $display("grant %s addr %h write %b", host_grant ? "H" : "D", eng_addr, eng_write);
        if (host_grant) host_addr = $urandom; else disp_addr = $urandom;
        eng_lat = $urandom_range(0, 2); eng_len = $urandom_range(0, 4);
        ng++;
      end
    end
    checks++;
    if (ng != 10) begin errors++; $display("FAIL order_count got %0d grants required 10", ng); end
    disp_req = 1'b0; host_req = 1'b0;
    t = 0;
    while (nd < ng && t < 100) begin tick(); t++; if (disp_done || host_done) nd++; end
    checks++;
    if (nd != ng) begin errors++; $display("FAIL order_drain got %0d dones required %0d", nd, ng); end
  endtask

  task automatic test_host_only;
    int t, dp;
    eng_lat = 0; eng_len = 2;
    host_addr = 24'h0A0040; host_req = 1'b1;
    t = 0; dp = 0;
    while (!host_grant && t < 10) begin tick(); t++; if (disp_grant || disp_done) dp++; end
    checks++;
    if (host_grant !== 1'b1 || eng_write !== 1'b1 || eng_addr !== 24'h0A0040) begin
      errors++; $display("FAIL host_cmd got grant %b write %b addr %h required 1 1 0a0040", host_grant, eng_write, eng_addr);
    end
    $display("grant H addr %h write %b", eng_addr, eng_write);
    host_req = 1'b0;
    t = 0;
    while (!host_done && t < 50) begin tick(); t++; if (disp_grant || disp_done) dp++; end
    checks++;
    if (!host_done || cyc != done_cyc + 1) begin
      errors++; $display("FAIL host_done_timing got done=%b at cycle %0d required 1 at cycle %0d", host_done, cyc, done_cyc + 1);
    end
    repeat (3) begin tick(); if (disp_grant || disp_done) dp++; end
    checks++;
    if (dp != 0) begin errors++; $display("FAIL host_only_disp_pulses got %0d required 0", dp); end
  endtask

  task automatic test_random;
    int m, ng, nd, t, out_owner, d_wait, h_wait;
    bit d_pend, h_pend, prev_d, prev_h, bad;
    logic dg, hg, dd, hd;
    m = 0; ng = 0; nd = 0; t = 0; out_owner = 0; d_wait = 0; h_wait = 0;
    d_pend = 0; h_pend = 0; prev_d = 0; prev_h = 0;
    disp_req = 1'b0; host_req = 1'b0;
    while ((ng < 40 || out_owner != 0) && t < 4000) begin
      tick(); t++;
      dg = disp_grant; hg = host_grant; dd = disp_done; hd = host_done;
      checks++;
      if (dg && hg) begin errors++; $display("FAIL rand_double_grant at cycle %0d got 2 grants required 1", cyc); end
      if (dd || hd) begin
        checks++;
        if ((dd && out_owner != 1) || (hd && out_owner != 2) || (dd && hd) || cyc != done_cyc + 1) begin
          errors++; $display("FAIL rand_done got disp %b host %b at cycle %0d required owner %0d at cycle %0d",
                             dd, hd, cyc, out_owner, done_cyc + 1);
        end
        out_owner = 0; nd++;
      end
      if (dg || hg) begin
        checks++;
        if (out_owner != 0) begin errors++; $display("FAIL rand_overlap got owner %0d busy required 0", out_owner); end
        if (dg) bad = !prev_d || (prev_h && m == MAXS);
        else    bad = !prev_h || (prev_d && m != MAXS);
        checks++;
        if (bad) begin
          errors++; $display("FAIL rand_arb got %s (d=%b h=%b streak=%0d) required %s", dg ? "D" : "H",
                             prev_d, prev_h, m, (prev_d && (!prev_h || m != MAXS)) ? "D" : "H");
        end
        checks++;
        if (eng_addr !== align(dg ? disp_addr : host_addr) || eng_write !== hg) begin
          errors++; $display("FAIL rand_cmd got addr %h write %b required addr %h write %b",
                             eng_addr, eng_write, align(dg ? disp_addr : host_addr), hg);
        end
        $display("grant %s addr %h write %b streak %0d", dg ? "D" : "H", eng_addr, eng_write, m);
        out_owner = dg ? 1 : 2;
        ng++;
        eng_lat = $urandom_range(0, 2); eng_len = $urandom_range(0, 4);
        if (dg) begin d_pend = 0; d_wait = $urandom_range(0, 3); end
        else    begin h_pend = 0; h_wait = $urandom_range(0, 3); end
      end
      if (!prev_h || hg) m = 0;
      else if (dg && m < MAXS) m++;
      if (ng >= 40) begin
        d_pend = 0; h_pend = 0;
      end else begin
        if (!d_pend) begin
          if (d_wait > 0) d_wait--;
          else if ($urandom_range(0, 1) == 1) begin d_pend = 1; disp_addr = $urandom; end
        end
        if (!h_pend) begin
          if (h_wait > 0) h_wait--;
          else if ($urandom_range(0, 1) == 1) begin h_pend = 1; host_addr = $urandom; end
        end
      end
      disp_req = d_pend; host_req = h_pend;
      prev_d = d_pend; prev_h = h_pend;
    end
    checks++;
    if (ng < 40 || nd != ng) begin errors++; $display("FAIL rand_count got %0d grants %0d dones required 40 equal", ng, nd); end
  endtask

  task automatic test_reset_busy;
    int t, p;
    eng_lat = 0; eng_len = 20;
    disp_addr = $urandom; disp_req = 1'b1;
    t = 0;
    while (!disp_grant && t < 10) begin tick(); t++; end
    disp_req = 1'b0;
    t = 0;
    while (!eng_start && t < 10) begin tick(); t++; end
    while (eng_start && t < 20) begin tick(); t++; end
    checks++;
    if (eng_start !== 1'b0 || t >= 20) begin errors++; $display("FAIL reach_busy got start %b after %0d cycles required 0", eng_start, t); end
    reset = 1'b1;
    tick();
    checks++;
    if ({disp_grant, disp_done, host_grant, host_done, eng_start, eng_write, timeout_err} !== 7'b0 || eng_addr !== 24'h0) begin
      errors++; $display("FAIL reset_busy got flags %b addr %h required 0 000000",
                         {disp_grant, disp_done, host_grant, host_done, eng_start, eng_write, timeout_err}, eng_addr);
    end
    p = 0;
    repeat (2) begin tick(); if (disp_done || host_done) p++; end
    reset = 1'b0;
    repeat (30) begin tick(); if (disp_done || host_done || disp_grant || host_grant) p++; end
    checks++;
    if (p != 0) begin errors++; $display("FAIL reset_busy_pulses got %0d required 0", p); end
    $display("reset in busy: outputs checked");
  endtask

`ifdef PSRAM_ARB_TIMEOUT_EN
  task automatic test_timeout;
    int t, gc;
    eng_hang = 1'b1; eng_lat = 0; eng_len = 0;
    disp_addr = $urandom; disp_req = 1'b1;
    t = 0;
    while (!disp_grant && t < 10) begin tick(); t++; end
    gc = cyc;
    disp_req = 1'b0;
    t = 0;
    while (!timeout_err && t < 40) begin tick(); t++; end
    checks++;
    if (!timeout_err || cyc - gc != 16) begin
      errors++; $display("FAIL timeout_time got err %b after %0d cycles required 1 after 16", timeout_err, cyc - gc);
    end
    checks++;
    if (disp_done !== 1'b1 || host_done !== 1'b0) begin
      errors++; $display("FAIL timeout_done got disp %b host %b required 1 0", disp_done, host_done);
    end
    repeat (5) tick();
    checks++;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b required 1", timeout_err); end
    eng_hang = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b required 0", timeout_err); end
    $display("timeout: checked");
  endtask
`endif

  initial begin
    test_reset();
    test_init_hold();
    test_order();
    test_host_only();
    test_random();
    test_reset_busy();
`ifdef PSRAM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
